// File: rtl/cop0_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// selector package + cop0_write_sequencer_if
//
// Purpose: the shared COP0 mux select encoding and the request/write bus of
// the COP0 write sequencer.
//
// Interface signals:
//   exc_req/exc_code/exc_pc/exc_bd  exception request (held until exc_ack)
//   eret_req                        ERET request (held until eret_ack)
//   op_req/op_src/op_addr           single-cycle COP0 op request
//   status                          current Status register value
//   mux_y/mux_wmask                 data / write mask from the COP0 mux
//   exc_ack/eret_ack/op_ack         one-cycle grant pulses
//   cop0_src                        select driven to the COP0 mux
//   cop0_we/waddr/wdata/wmask       register-file write port
//   stall/redirect/redirect_errorepc  pipeline control
// Modports: slave = sequencer side, master = pipeline/requester side.
// ---------------------------------------------------------------------------
package selector;
  typedef enum logic [2:0] {
    COP0_SRC_RT          = 3'd0,
    COP0_SRC_LLADDR      = 3'd1,
    COP0_SRC_STATUS_EI   = 3'd2,
    COP0_SRC_STATUS_DI   = 3'd3,
    COP0_SRC_STATUS_EXL  = 3'd4,
    COP0_SRC_STATUS_ERET = 3'd5
  } cop0_source;
endpackage

interface cop0_write_sequencer_if;
  logic                 exc_req;
  logic [4:0]           exc_code;
  logic [31:0]          exc_pc;
  logic                 exc_bd;
  logic                 eret_req;
  logic                 op_req;
  selector::cop0_source op_src;
  logic [4:0]           op_addr;
  logic [31:0]          status;
  logic [31:0]          mux_y;
  logic [31:0]          mux_wmask;
  logic                 exc_ack;
  logic                 eret_ack;
  logic                 op_ack;
  selector::cop0_source cop0_src;
  logic                 cop0_we;
  logic [4:0]           cop0_waddr;
  logic [31:0]          cop0_wdata;
  logic [31:0]          cop0_wmask;
  logic                 stall;
  logic                 redirect;
  logic                 redirect_errorepc;

  modport slave (
    input  exc_req, exc_code, exc_pc, exc_bd, eret_req, op_req, op_src,
           op_addr, status, mux_y, mux_wmask,
    output exc_ack, eret_ack, op_ack, cop0_src, cop0_we, cop0_waddr,
           cop0_wdata, cop0_wmask, stall, redirect, redirect_errorepc
  );

  modport master (
    output exc_req, exc_code, exc_pc, exc_bd, eret_req, op_req, op_src,
           op_addr, status, mux_y, mux_wmask,
    input  exc_ack, eret_ack, op_ack, cop0_src, cop0_we, cop0_waddr,
           cop0_wdata, cop0_wmask, stall, redirect, redirect_errorepc
  );
endinterface

// File: rtl/cop0_write_sequencer.sv
// ---------------------------------------------------------------------------
// cop0_write_sequencer
//
// Purpose: single-port write scheduler for the COP0 register file. Arbitrates
// exception entry > ERET > single-cycle COP0 ops, sequences exception entry as
// an EPC -> Cause -> Status write burst with stall and a redirect pulse.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      cop0_write_sequencer_if.slave (requests, mux feedback, write port)
//
// Optional feature macro: COP0_SEQ_NESTED_EPC_EN
//   defined   : EPC write is skipped when Status.EXL is already set at accept
//   undefined : EPC is always written
//
// Grants and the op write path are combinational from the request because an
// op must be acked and written in the cycle it is presented, and the written
// data comes back from the external mux that this block steers.
// ---------------------------------------------------------------------------
module cop0_write_sequencer #(
  parameter logic [4:0] EPC_ADDR    = 5'd14,
  parameter logic [4:0] CAUSE_ADDR  = 5'd13,
  parameter logic [4:0] STATUS_ADDR = 5'd12
) (
  input logic               clk,
  input logic               reset_n,
  cop0_write_sequencer_if.slave bus
);
  import selector::*;

  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_ERL_BIT = 2;
  localparam logic [31:0] CAUSE_WMASK = 32'h8000_007C;

`ifdef COP0_SEQ_NESTED_EPC_EN
  localparam logic NESTED_EPC_EN = 1'b1;
`else
  localparam logic NESTED_EPC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    EXC_EPC     = 3'd1,
    EXC_CAUSE   = 3'd2,
    EXC_STATUS  = 3'd3,
    ERET_STATUS = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] epc_r;
  logic [4:0]  code_r;
  logic        bd_r;

  logic        exc_ack_s;
  logic        eret_ack_s;
  logic        op_ack_s;
  cop0_source  cop0_src_s;
  logic        cop0_we_s;
  logic [4:0]  cop0_waddr_s;
  logic [31:0] cop0_wdata_s;
  logic [31:0] cop0_wmask_s;
  logic        stall_s;
  logic        redirect_s;
  logic        redirect_errorepc_s;

  // A delay-slot fault restarts at the branch, one word earlier.
  function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  // Cause layout: BD in bit 31, ExcCode in bits 6:2.
  function automatic logic [31:0] cause_word(input logic bd, input logic [4:0] code);
    return {bd, 24'd0, code, 2'b00};
  endfunction

  // State register and captured exception context.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      epc_r   <= 32'd0;
      code_r  <= 5'd0;
      bd_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.exc_req) begin
            epc_r  <= epc_value(bus.exc_pc, bus.exc_bd);
            code_r <= bus.exc_code;
            bd_r   <= bus.exc_bd;
            // Nested exception keeps the outer EPC intact.
            if (NESTED_EPC_EN && bus.status[STATUS_EXL_BIT]) begin
              state_r <= EXC_CAUSE;
            end else begin
              state_r <= EXC_EPC;
            end
          end else if (bus.eret_req) begin
            state_r <= ERET_STATUS;
          end else begin
            state_r <= IDLE;
          end
        end
        EXC_EPC:     state_r <= EXC_CAUSE;
        EXC_CAUSE:   state_r <= EXC_STATUS;
        EXC_STATUS:  state_r <= IDLE;
        ERET_STATUS: state_r <= IDLE;
        default:     state_r <= IDLE;
      endcase
    end
  end

  // Grant, write-port and pipeline-control decode.
  always_comb begin
    exc_ack_s           = 1'b0;
    eret_ack_s          = 1'b0;
    op_ack_s            = 1'b0;
    cop0_src_s          = COP0_SRC_RT;
    cop0_we_s           = 1'b0;
    cop0_waddr_s        = 5'd0;
    cop0_wdata_s        = 32'd0;
    cop0_wmask_s        = 32'd0;
    stall_s             = 1'b0;
    redirect_s          = 1'b0;
    redirect_errorepc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.exc_req) begin
          exc_ack_s = 1'b1;
          stall_s   = 1'b1;
        end else if (bus.eret_req) begin
          eret_ack_s = 1'b1;
          stall_s    = 1'b1;
        end else if (bus.op_req) begin
          op_ack_s     = 1'b1;
          cop0_src_s   = bus.op_src;
          cop0_we_s    = 1'b1;
          cop0_waddr_s = bus.op_addr;
          cop0_wdata_s = bus.mux_y;
          cop0_wmask_s = bus.mux_wmask;
        end else begin
          cop0_src_s = COP0_SRC_RT;
        end
      end
      EXC_EPC: begin
        stall_s      = 1'b1;
        cop0_we_s    = 1'b1;
        cop0_waddr_s = EPC_ADDR;
        cop0_wdata_s = epc_r;
        cop0_wmask_s = 32'hFFFF_FFFF;
      end
      EXC_CAUSE: begin
        stall_s      = 1'b1;
        cop0_we_s    = 1'b1;
        cop0_waddr_s = CAUSE_ADDR;
        cop0_wdata_s = cause_word(bd_r, code_r);
        cop0_wmask_s = CAUSE_WMASK;
      end
      // Final burst states drop stall so fetch resumes with the redirect.
      EXC_STATUS: begin
        cop0_src_s   = COP0_SRC_STATUS_EXL;
        cop0_we_s    = 1'b1;
        cop0_waddr_s = STATUS_ADDR;
        cop0_wdata_s = bus.mux_y;
        cop0_wmask_s = bus.mux_wmask;
        redirect_s   = 1'b1;
      end
      ERET_STATUS: begin
        cop0_src_s          = COP0_SRC_STATUS_ERET;
        cop0_we_s           = 1'b1;
        cop0_waddr_s        = STATUS_ADDR;
        cop0_wdata_s        = bus.mux_y;
        cop0_wmask_s        = bus.mux_wmask;
        redirect_s          = 1'b1;
        redirect_errorepc_s = bus.status[STATUS_ERL_BIT];
      end
      default: begin
        cop0_src_s = COP0_SRC_RT;
      end
    endcase
  end

  assign bus.exc_ack           = exc_ack_s;
  assign bus.eret_ack          = eret_ack_s;
  assign bus.op_ack            = op_ack_s;
  assign bus.cop0_src          = cop0_src_s;
  assign bus.cop0_we           = cop0_we_s;
  assign bus.cop0_waddr        = cop0_waddr_s;
  assign bus.cop0_wdata        = cop0_wdata_s;
  assign bus.cop0_wmask        = cop0_wmask_s;
  assign bus.stall             = stall_s;
  assign bus.redirect          = redirect_s;
  assign bus.redirect_errorepc = redirect_errorepc_s;

endmodule

// File: tb/tb_cop0_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cop0_write_sequencer
//
// Drives requests into cop0_write_sequencer through its interface, models the
// COP0 mux as a simple function of the select, and checks every register-file
// write against a queue of expected writes filled by the scenario tasks.
// Handshake and stall timing are checked inline in each scenario task.
// ---------------------------------------------------------------------------
module tb_cop0_write_sequencer;
  import selector::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cop0_write_sequencer_if bus ();

  cop0_write_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Mux model: each select yields a distinct, recognisable data/mask pair.
  function automatic logic [31:0] mux_data(input cop0_source s);
    return 32'hC0DE_0000 | {29'd0, s};
  endfunction
  function automatic logic [31:0] mux_mask(input cop0_source s);
    return 32'h0000_0F00 | {29'd0, s};
  endfunction

  assign bus.mux_y     = mux_data(bus.cop0_src);
  assign bus.mux_wmask = mux_mask(bus.cop0_src);

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
    cop0_source  src;
    logic        redir;
    logic        eepc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;
  int compared = 0;
  int mismatched = 0;

`ifdef COP0_SEQ_NESTED_EPC_EN
  localparam logic NESTED = 1'b1;
`else
  localparam logic NESTED = 1'b0;
`endif

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] m,
                         input cop0_source s, input logic r, input logic e);
    wr_t w;
    w.addr = a; w.data = d; w.mask = m; w.src = s; w.redir = r; w.eepc = e;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_req  = 1'b0;
    bus.exc_code = 5'd0;
    bus.exc_pc   = 32'd0;
    bus.exc_bd   = 1'b0;
    bus.eret_req = 1'b0;
    bus.op_req   = 1'b0;
    bus.op_src   = COP0_SRC_RT;
    bus.op_addr  = 5'd0;
    bus.status   = 32'd0;
  endtask

  // Write monitor: every DUT write is popped against the expected queue.
  always @(negedge clk) begin
    if (bus.cop0_we === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL write_unexpected: got addr=%0d data=%h mask=%h, expected no write",
                 bus.cop0_waddr, bus.cop0_wdata, bus.cop0_wmask);
      end else begin
        mon_w = exp_q.pop_front();
        if (bus.cop0_waddr !== mon_w.addr || bus.cop0_wdata !== mon_w.data ||
            bus.cop0_wmask !== mon_w.mask || bus.cop0_src !== mon_w.src ||
            bus.redirect !== mon_w.redir || bus.redirect_errorepc !== mon_w.eepc) begin
          mismatched++;
          $display("FAIL write: got addr=%0d data=%h mask=%h src=%0d redir=%b eepc=%b, expected addr=%0d data=%h mask=%h src=%0d redir=%b eepc=%b",
                   bus.cop0_waddr, bus.cop0_wdata, bus.cop0_wmask, bus.cop0_src,
                   bus.redirect, bus.redirect_errorepc, mon_w.addr, mon_w.data,
                   mon_w.mask, mon_w.src, mon_w.redir, mon_w.eepc);
        end
      end
    end else if (bus.redirect !== 1'b0) begin
      compared++;
      mismatched++;
      $display("FAIL redirect_no_write: got redirect=%b we=%b, expected redirect only with a write",
               bus.redirect, bus.cop0_we);
    end
  end

  task automatic check_queue_empty(input string name);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_pending: got %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [79:0] got;
    logic [79:0] expv;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    expv = {3'b000, 1'b0, COP0_SRC_RT, 5'd0, 32'd0, 32'd0, 3'b000};
    @(negedge clk);
    got = {bus.exc_ack, bus.eret_ack, bus.op_ack, bus.cop0_we, bus.cop0_src, bus.cop0_waddr,
           bus.cop0_wdata, bus.cop0_wmask, bus.stall, bus.redirect, bus.redirect_errorepc};
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h, expected %h", got, expv);
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    got = {bus.exc_ack, bus.eret_ack, bus.op_ack, bus.cop0_we, bus.cop0_src, bus.cop0_waddr,
           bus.cop0_wdata, bus.cop0_wmask, bus.stall, bus.redirect, bus.redirect_errorepc};
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL idle_after_reset: got %h, expected %h", got, expv);
    end
    tick();
  endtask

  task automatic test_exception(input string name, input logic [4:0] code, input logic [31:0] pc,
                                input logic bd, input logic [31:0] st, input logic skip_epc,
                                input logic [31:0] exp_epc, input logic [31:0] exp_cause);
    int n;
    logic [3:0] got;
    logic [3:0] expv;
    bus.status   = st;
    bus.exc_code = code;
    bus.exc_pc   = pc;
    bus.exc_bd   = bd;
    bus.exc_req  = 1'b1;
    if (!skip_epc) push_wr(5'd14, exp_epc, 32'hFFFF_FFFF, COP0_SRC_RT, 1'b0, 1'b0);
    push_wr(5'd13, exp_cause, 32'h8000_007C, COP0_SRC_RT, 1'b0, 1'b0);
    push_wr(5'd12, mux_data(COP0_SRC_STATUS_EXL), mux_mask(COP0_SRC_STATUS_EXL),
            COP0_SRC_STATUS_EXL, 1'b1, 1'b0);
    n = skip_epc ? 3 : 4;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      expv = {(c == 0), (c < n - 1), (c >= 1 && c <= n - 1), (c == n - 1)};
      got  = {bus.exc_ack, bus.stall, bus.cop0_we, bus.redirect};
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL %s_cycle%0d: got ack/stall/we/redirect=%b, expected %b", name, c, got, expv);
      end
      tick();
      if (c == 0) bus.exc_req = 1'b0;
    end
    check_queue_empty(name);
    bus.status = 32'd0;
  endtask

  task automatic test_eret_erl();
    logic [3:0] got;
    logic [3:0] expv;
    bus.status   = 32'h0000_0004;
    bus.eret_req = 1'b1;
    push_wr(5'd12, mux_data(COP0_SRC_STATUS_ERET), mux_mask(COP0_SRC_STATUS_ERET),
            COP0_SRC_STATUS_ERET, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expv = {(c == 0), (c == 0), (c == 1), (c == 1)};
      got  = {bus.eret_ack, bus.stall, bus.cop0_we, bus.redirect};
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL eret_erl_cycle%0d: got ack/stall/we/redirect=%b, expected %b", c, got, expv);
      end
      tick();
      if (c == 0) bus.eret_req = 1'b0;
    end
    check_queue_empty("eret_erl");
    bus.status = 32'd0;
  endtask

  task automatic test_priority();
    logic [2:0] got;
    logic [2:0] expv;
    bus.status   = 32'd0;
    bus.exc_code = 5'h0C;
    bus.exc_pc   = 32'h8000_0400;
    bus.exc_bd   = 1'b0;
    bus.op_src   = COP0_SRC_LLADDR;
    bus.op_addr  = 5'd17;
    bus.exc_req  = 1'b1;
    bus.eret_req = 1'b1;
    bus.op_req   = 1'b1;
    push_wr(5'd14, 32'h8000_0400, 32'hFFFF_FFFF, COP0_SRC_RT, 1'b0, 1'b0);
    push_wr(5'd13, 32'h0000_0030, 32'h8000_007C, COP0_SRC_RT, 1'b0, 1'b0);
    push_wr(5'd12, mux_data(COP0_SRC_STATUS_EXL), mux_mask(COP0_SRC_STATUS_EXL),
            COP0_SRC_STATUS_EXL, 1'b1, 1'b0);
    push_wr(5'd12, mux_data(COP0_SRC_STATUS_ERET), mux_mask(COP0_SRC_STATUS_ERET),
            COP0_SRC_STATUS_ERET, 1'b1, 1'b0);
    push_wr(5'd17, mux_data(COP0_SRC_LLADDR), mux_mask(COP0_SRC_LLADDR),
            COP0_SRC_LLADDR, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      expv = {(c == 0), (c == 4), (c == 6)};
      got  = {bus.exc_ack, bus.eret_ack, bus.op_ack};
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL priority_cycle%0d: got exc/eret/op ack=%b, expected %b", c, got, expv);
      end
      tick();
      if (c == 0) bus.exc_req = 1'b0;
      if (c == 4) bus.eret_req = 1'b0;
      if (c == 6) bus.op_req = 1'b0;
    end
    check_queue_empty("priority");
  endtask

  task automatic test_back_to_back();
    cop0_source s;
    logic [1:0] got;
    for (int i = 0; i < 4; i++) begin
      s = cop0_source'(3'(i));
      bus.op_req  = 1'b1;
      bus.op_src  = s;
      bus.op_addr = 5'd20 + 5'(i);
      push_wr(5'd20 + 5'(i), mux_data(s), mux_mask(s), s, 1'b0, 1'b0);
      @(negedge clk);
      got = {bus.op_ack, bus.stall};
      compared++;
      if (got !== 2'b10) begin
        mismatched++;
        $display("FAIL b2b_op%0d: got ack/stall=%b, expected 10", i, got);
      end
      tick();
    end
    bus.op_req = 1'b0;
    @(negedge clk);
    got = {bus.op_ack, bus.cop0_we};
    compared++;
    if (got !== 2'b00) begin
      mismatched++;
      $display("FAIL b2b_idle: got ack/we=%b, expected 00", got);
    end
    tick();
    check_queue_empty("b2b");
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] got;
    bus.status   = 32'd0;
    bus.exc_code = 5'h04;
    bus.exc_pc   = 32'h8000_0500;
    bus.exc_bd   = 1'b0;
    bus.exc_req  = 1'b1;
    push_wr(5'd14, 32'h8000_0500, 32'hFFFF_FFFF, COP0_SRC_RT, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    bus.exc_req = 1'b0;
    @(negedge clk);
    tick();
    // Now in the Cause-write cycle.
    reset_n = 1'b0;
    #1;
    got = {bus.cop0_we, bus.stall, bus.redirect};
    compared++;
    if (got !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_mid_burst_immediate: got we/stall/redirect=%b, expected 000", got);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = {bus.cop0_we, bus.stall, bus.redirect};
      compared++;
      if (got !== 3'b000) begin
        mismatched++;
        $display("FAIL reset_mid_burst_after%0d: got we/stall/redirect=%b, expected 000", c, got);
      end
      tick();
    end
    check_queue_empty("reset_mid_burst");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exception("exc_basic", 5'h04, 32'h8000_0100, 1'b0, 32'd0, 1'b0,
                   32'h8000_0100, 32'h0000_0010);
    test_exception("exc_bd", 5'h0A, 32'h8000_0204, 1'b1, 32'd0, 1'b0,
                   32'h8000_0200, 32'h8000_0028);
    test_exception("exc_nested", 5'h08, 32'h8000_0300, 1'b0, 32'h0000_0002, NESTED,
                   32'h8000_0300, 32'h0000_0020);
    test_eret_erl();
    test_priority();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
